// File: rtl/coin_payer.sv
// Customer-side coin driver: latches a purse, picks a 15-cent payment plan,
// feeds coins to the vendor one per clock and records the vendor's response.
module coin_payer #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] nickels_in,
    input  logic [CNT_W-1:0] dimes_in,
    input  logic             newspaper,
    input  logic             change,
    output logic [1:0]       coin,
    output logic             busy,
    output logic             done,
    output logic             got_paper,
    output logic             got_change,
    output logic             error,
    output logic [CNT_W-1:0] nickels_left,
    output logic [CNT_W-1:0] dimes_left
);

    // Handshake: start is a one-cycle request honoured only in IDLE; done is a
    // one-cycle pulse that closes every accepted request, success or error.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAN,
        S_PAY,
        S_WAIT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        P_NONE,
        P_DN,
        P_NNN,
        P_DD
    } plan_e;

    state_e           state_q;
    plan_e            plan_q;
    logic [1:0]       idx_q;
    logic [4:0]       paid_q;
    logic [TW-1:0]    timer_q;
    logic [1:0]       coin_q;
    logic             busy_q;
    logic             done_q;
    logic             got_paper_q;
    logic             got_change_q;
    logic             error_q;
    logic [CNT_W-1:0] nickels_q;
    logic [CNT_W-1:0] dimes_q;

    plan_e      plan_sel;
    plan_e      plan_use;
    logic [1:0] idx_use;
    logic [1:0] next_coin;
    logic [1:0] plan_len;
    logic       is_dime;
    logic       last_coin;
    logic [4:0] coin_val;

    // Plan priority favours exact payment; two dimes is the only overpay.
    always_comb begin
        plan_sel = P_NONE;
        if (dimes_q != '0 && nickels_q != '0) begin
            plan_sel = P_DN;
        end else if (int'(nickels_q) >= 3) begin
            plan_sel = P_NNN;
        end else if (int'(dimes_q) >= 2) begin
            plan_sel = P_DD;
        end
    end

    // PLAN issues the first coin of the freshly chosen plan, PAY the rest.
    always_comb begin
        plan_use = (state_q == S_PLAN) ? plan_sel : plan_q;
        idx_use  = (state_q == S_PLAN) ? 2'd0 : idx_q;
        case (plan_use)
            P_DN:    next_coin = (idx_use == 2'd0) ? COIN_DIME : COIN_NICKEL;
            P_NNN:   next_coin = COIN_NICKEL;
            P_DD:    next_coin = COIN_DIME;
            default: next_coin = COIN_NONE;
        endcase
        case (plan_q)
            P_NNN:      plan_len = 2'd3;
            P_DN, P_DD: plan_len = 2'd2;
            default:    plan_len = 2'd0;
        endcase
        last_coin = (idx_q == plan_len);
        is_dime   = (next_coin == COIN_DIME);
        coin_val  = is_dime ? 5'd10 : 5'd5;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            plan_q       <= P_NONE;
            idx_q        <= 2'd0;
            paid_q       <= 5'd0;
            timer_q      <= '0;
            coin_q       <= COIN_NONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            got_paper_q  <= 1'b0;
            got_change_q <= 1'b0;
            error_q      <= 1'b0;
            nickels_q    <= '0;
            dimes_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    coin_q <= COIN_NONE;
                    if (start) begin
                        nickels_q    <= nickels_in;
                        dimes_q      <= dimes_in;
                        got_paper_q  <= 1'b0;
                        got_change_q <= 1'b0;
                        error_q      <= 1'b0;
                        paid_q       <= 5'd0;
                        busy_q       <= 1'b1;
                        state_q      <= S_PLAN;
                    end
                end

                S_PLAN: begin
                    if (plan_sel == P_NONE) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        coin_q  <= COIN_NONE;
                        state_q <= S_DONE;
                    end else begin
                        plan_q <= plan_sel;
                        idx_q  <= 2'd1;
                        coin_q <= next_coin;
                        paid_q <= paid_q + coin_val;
                        if (is_dime) begin
                            dimes_q <= dimes_q - CNT_W'(1);
                        end else begin
                            nickels_q <= nickels_q - CNT_W'(1);
                        end
                        state_q <= S_PAY;
                    end
                end

                S_PAY: begin
                    if (newspaper) begin
                        // Paper before full payment means the vendor is out of step.
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        coin_q  <= COIN_NONE;
                        state_q <= S_DONE;
                    end else if (last_coin) begin
                        coin_q  <= COIN_NONE;
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        idx_q  <= idx_q + 2'd1;
                        coin_q <= next_coin;
                        paid_q <= paid_q + coin_val;
                        if (is_dime) begin
                            dimes_q <= dimes_q - CNT_W'(1);
                        end else begin
                            nickels_q <= nickels_q - CNT_W'(1);
                        end
                    end
                end

                S_WAIT: begin
                    coin_q <= COIN_NONE;
                    if (newspaper) begin
                        got_paper_q  <= 1'b1;
                        got_change_q <= change;
                        error_q      <= (change != (paid_q == 5'd20));
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                S_DONE: begin
                    coin_q  <= COIN_NONE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    coin_q  <= COIN_NONE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign coin         = coin_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign got_paper    = got_paper_q;
    assign got_change   = got_change_q;
    assign error        = error_q;
    assign nickels_left = nickels_q;
    assign dimes_left   = dimes_q;

endmodule

// File: tb/tb_coin_payer.sv
// Bench for coin_payer: a behavioural vendor plus a purse-level reference model
// predicting the coin sequence, done latency, result flags and leftover purse.
module tb_coin_payer;
  localparam int CNT_W = 4;
  localparam int TIMEOUT = 4;
  localparam int V_NORMAL = 0;
  localparam int V_STUB = 1;
  localparam int V_EARLY = 2;
  localparam int V_FLIP = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] nickels_in = '0;
  logic [CNT_W-1:0] dimes_in = '0;
  logic newspaper;
  logic change;
  logic [1:0] coin;
  logic busy, done, got_paper, got_change, error;
  logic [CNT_W-1:0] nickels_left, dimes_left;

  int errors = 0;
  int checks = 0;
  int vmode = V_NORMAL;
  logic [4:0] v_credit;
  logic [4:0] v_sum;
  logic [1:0] exp_q[$];

  coin_payer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .start(start),
    .nickels_in(nickels_in), .dimes_in(dimes_in),
    .newspaper(newspaper), .change(change),
    .coin(coin), .busy(busy), .done(done),
    .got_paper(got_paper), .got_change(got_change), .error(error),
    .nickels_left(nickels_left), .dimes_left(dimes_left)
  );

  // clock / reset
  always #5 clock = ~clock;

  // vendor: 15 cents buys a paper, 20 cents also returns a nickel
  always_comb v_sum = v_credit + ((coin == 2'b10) ? 5'd10 : 5'd5);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      v_credit <= 5'd0;
      newspaper <= 1'b0;
      change <= 1'b0;
    end else begin
      newspaper <= 1'b0;
      change <= 1'b0;
      if (coin != 2'b00 && vmode != V_STUB) begin
        if (vmode == V_EARLY || v_sum >= 5'd15) begin
          newspaper <= 1'b1;
          change <= (v_sum == 5'd20) ^ (vmode == V_FLIP);
          v_credit <= 5'd0;
        end else begin
          v_credit <= v_sum;
        end
      end
    end
  end

  // driver + scoreboard for one transaction
  task automatic run_txn(input int n, input int d, input int vm, input bit poke, input string tag);
    int lat, n_used, d_used, paid, sz;
    bit exp_paper, exp_chg, exp_err, seen;
    logic [1:0] exp_c;
    exp_q.delete();
    if (d >= 1 && n >= 1) begin
      exp_q.push_back(2'b10);
      exp_q.push_back(2'b01);
    end else if (n >= 3) begin
      repeat (3) exp_q.push_back(2'b01);
    end else if (d >= 2) begin
      repeat (2) exp_q.push_back(2'b10);
    end
    if (vm == V_EARLY && exp_q.size() > 2) void'(exp_q.pop_back());
    sz = exp_q.size();
    n_used = 0; d_used = 0; paid = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i] == 2'b10) begin d_used++; paid += 10; end
      else begin n_used++; paid += 5; end
    end
    exp_chg = 1'b0;
    if (sz == 0) begin
      lat = 1; exp_paper = 0; exp_err = 1;
    end else if (vm == V_STUB) begin
      lat = sz + 1 + TIMEOUT; exp_paper = 0; exp_err = 1;
    end else if (vm == V_EARLY) begin
      lat = 3; exp_paper = 0; exp_err = 1;
    end else if (vm == V_FLIP) begin
      lat = sz + 2; exp_paper = 1; exp_chg = (paid != 20); exp_err = 1;
    end else begin
      lat = sz + 2; exp_paper = 1; exp_chg = (paid == 20); exp_err = 0;
    end

    @(negedge clock);
    vmode = vm;
    start = 1'b1;
    nickels_in = CNT_W'(n);
    dimes_in = CNT_W'(d);
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || coin !== 2'b00 || error !== 1'b0 || got_paper !== 1'b0) begin
      errors++;
      $display("FAIL %s plan_cycle: busy=%b coin=%b error=%b got_paper=%b, want 1 00 0 0", tag, busy, coin, error, got_paper);
    end
    checks++;
    if (nickels_left !== CNT_W'(n) || dimes_left !== CNT_W'(d)) begin
      errors++;
      $display("FAIL %s latch: left=%0d/%0d want %0d/%0d", tag, nickels_left, dimes_left, n, d);
    end

    seen = 0;
    for (int it = 1; it <= 40; it++) begin
      @(negedge clock);
      exp_c = (it <= sz) ? exp_q[it-1] : 2'b00;
      checks++;
      if (coin !== exp_c) begin
        errors++;
        $display("FAIL %s coin[%0d]: got %b want %b", tag, it, coin, exp_c);
      end
      if (done === 1'b1) begin
        seen = 1;
        checks++;
        if (it != lat) begin
          errors++;
          $display("FAIL %s done_latency: got %0d want %0d", tag, it, lat);
        end
        checks++;
        if (got_paper !== exp_paper || got_change !== exp_chg || error !== exp_err || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s result: paper=%b change=%b error=%b busy=%b want %b %b %b 1",
                   tag, got_paper, got_change, error, busy, exp_paper, exp_chg, exp_err);
        end
        checks++;
        if (nickels_left !== CNT_W'(n - n_used) || dimes_left !== CNT_W'(d - d_used)) begin
          errors++;
          $display("FAIL %s left: got %0d/%0d want %0d/%0d", tag, nickels_left, dimes_left, n - n_used, d - d_used);
        end
        break;
      end
      if (poke) begin
        start = 1'b1;
        nickels_in = CNT_W'($urandom_range(0, 15));
        dimes_in = CNT_W'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no done in 40 cycles want done at %0d", tag, lat);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || coin !== 2'b00 || got_paper !== exp_paper || error !== exp_err) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b coin=%b paper=%b error=%b want 0 0 00 %b %b",
               tag, done, busy, coin, got_paper, error, exp_paper, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    nickels_in = 4'd5;
    dimes_in = 4'd5;
    repeat (2) @(negedge clock);
    checks++;
    if (coin !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || got_paper !== 1'b0 || got_change !== 1'b0 ||
        error !== 1'b0 || nickels_left !== '0 || dimes_left !== '0) begin
      errors++;
      $display("FAIL reset_values: coin=%b busy=%b done=%b paper=%b change=%b error=%b left=%0d/%0d want all zero",
               coin, busy, done, got_paper, got_change, error, nickels_left, dimes_left);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || nickels_left !== '0) begin
      errors++;
      $display("FAIL reset_start_ignored: busy=%b nickels_left=%0d want 0 0", busy, nickels_left);
    end
  endtask

  task automatic test_basic();
    run_txn(2, 3, V_NORMAL, 0, "dime_nickel");
    run_txn(3, 0, V_NORMAL, 0, "three_nickels");
    run_txn(0, 2, V_NORMAL, 0, "two_dimes");
  endtask

  task automatic test_insufficient();
    run_txn(2, 0, V_NORMAL, 0, "short_2_0");
    run_txn(0, 1, V_NORMAL, 0, "short_0_1");
    run_txn(0, 0, V_NORMAL, 0, "short_0_0");
  endtask

  task automatic test_timeout();
    run_txn(1, 1, V_STUB, 0, "timeout");
  endtask

  task automatic test_protocol();
    run_txn(1, 1, V_EARLY, 0, "early_paper_dn");
    run_txn(4, 0, V_EARLY, 0, "early_paper_nnn");
    run_txn(1, 1, V_FLIP, 0, "wrong_change_dn");
    run_txn(0, 3, V_FLIP, 0, "wrong_change_dd");
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    vmode = V_NORMAL;
    start = 1'b1;
    nickels_in = 4'd1;
    dimes_in = 4'd1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (coin !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_first_dime: coin=%b want 10", coin);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (coin !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || nickels_left !== '0 || dimes_left !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: coin=%b busy=%b done=%b error=%b left=%0d/%0d want 00 0 0 0 0/0",
               coin, busy, done, error, nickels_left, dimes_left);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || coin !== 2'b00 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet[%0d]: done=%b coin=%b busy=%b want 0 00 0", i, done, coin, busy);
      end
    end
    run_txn(1, 1, V_NORMAL, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_txn(0, 2, V_NORMAL, 1, "busy_start_dd");
    run_txn(3, 0, V_NORMAL, 1, "busy_start_nnn");
    run_txn(1, 1, V_STUB, 1, "busy_start_timeout");
  endtask

  task automatic test_max();
    run_txn(15, 15, V_NORMAL, 0, "max_15_15");
    run_txn(15, 0, V_NORMAL, 0, "max_15_0");
    run_txn(0, 15, V_NORMAL, 0, "max_0_15");
  endtask

  task automatic test_random();
    int n, d;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(0, 4);
        d = $urandom_range(0, 3);
      end else begin
        n = $urandom_range(0, 15);
        d = $urandom_range(0, 15);
      end
      run_txn(n, d, V_NORMAL, $urandom_range(0, 3) == 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_insufficient();
    test_timeout();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    test_max();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
